// File: rtl/level_pkg.sv
// Shared sizes and FSM encoding for the level memory read side.
// The writer and reader agree on these so one scan covers the whole map.
package level_pkg;

    localparam int LEVEL_ADDR_W = 6;
    localparam int LEVEL_DEPTH  = 1 << LEVEL_ADDR_W;
    localparam int LEVEL_DATA_W = 16;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_SCAN,
        RD_DRAIN
    } rd_state_t;

endpackage

// File: rtl/rd_fifo2.sv
// Two-entry FIFO holding {index, data} pairs between the RAM return and the consumer.
// Slot 0 is always the head, so the head can drive the outputs with no read mux.
module rd_fifo2 #(
    parameter int WIDTH = 22
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_entry_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] slot0_q;
    logic [WIDTH-1:0] slot1_q;
    logic [1:0]       count_q;

    // Pop shifts slot 1 forward; a push lands in the first free slot after that shift.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else if (flush_i) begin
            count_q <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b11: begin
                    if (count_q == 2'd2) begin
                        slot0_q <= slot1_q;
                        slot1_q <= push_entry_i;
                    end else begin
                        slot0_q <= push_entry_i;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        slot0_q <= push_entry_i;
                    end else begin
                        slot1_q <= push_entry_i;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    count_q <= count_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign head_o  = slot0_q;
    assign count_o = count_q;

endmodule

// File: rtl/level_map_reader.sv
// Once per frame, streams all level RAM entries with their index to the render/collision logic.
// A busy writer blocks new scans and aborts a running one.
module level_map_reader
    import level_pkg::*;
#(
    parameter int DATA_W = LEVEL_DATA_W,
    parameter int ADDR_W = LEVEL_ADDR_W,
    parameter int DEPTH  = LEVEL_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vs_i,
    input  logic              write_begin_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              ent_valid_o,
    input  logic              ent_ready_i,
    output logic [DATA_W-1:0] ent_data_o,
    output logic [ADDR_W-1:0] ent_index_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              aborted_o,
    output logic              skipped_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rd_state_t          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  tagAddr_q;
    logic               inflight_q;
    logic               aborted_q;
    logic               vsMeta_q, vsSync_q, vsPrev_q;

    logic               vsEdge;
    logic               abort;
    logic               pop;
    logic               issue;
    logic               lastIssue;
    logic [2:0]         occupancy;
    logic [1:0]         fifoCount;
    logic [ADDR_W+DATA_W-1:0] fifoHead;

    assign vsEdge    = vsSync_q & ~vsPrev_q;
    assign abort     = (state_q != RD_IDLE) & write_begin_i;
    assign pop       = ent_valid_o & ent_ready_i;
    assign occupancy = {1'b0, fifoCount} + {2'b00, inflight_q};
    // A pop in the same cycle frees a slot, which keeps one issue per cycle at full throughput.
    assign issue     = (state_q == RD_SCAN) && !write_begin_i &&
                       (occupancy < (3'd2 + {2'b00, pop}));
    assign lastIssue = issue && (addr_q == LAST_ADDR);

    assign frame_done_o = (state_q == RD_DRAIN) && !write_begin_i && pop &&
                          (ent_index_o == LAST_ADDR);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            RD_IDLE: begin
                if (vsEdge && !write_begin_i) begin
                    state_d = RD_SCAN;
                    addr_d  = '0;
                end
            end
            RD_SCAN: begin
                if (abort) begin
                    state_d = RD_IDLE;
                end else if (lastIssue) begin
                    state_d = RD_DRAIN;
                end else if (issue) begin
                    addr_d = addr_q + 1'b1;
                end
            end
            RD_DRAIN: begin
                if (abort || frame_done_o) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RD_IDLE;
            addr_q     <= '0;
            tagAddr_q  <= '0;
            inflight_q <= 1'b0;
            aborted_q  <= 1'b0;
            vsMeta_q   <= 1'b0;
            vsSync_q   <= 1'b0;
            vsPrev_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inflight_q <= issue;
            aborted_q  <= abort;
            vsMeta_q   <= vs_i;
            vsSync_q   <= vsMeta_q;
            vsPrev_q   <= vsSync_q;
            if (issue) begin
                tagAddr_q <= addr_q;
            end
        end
    end

    // An abort drops the in-flight return and flushes whatever is queued.
    rd_fifo2 #(
        .WIDTH(ADDR_W + DATA_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (inflight_q & ~abort),
        .push_entry_i({tagAddr_q, rd_data_i}),
        .pop_i       (pop),
        .flush_i     (abort),
        .head_o      (fifoHead),
        .count_o     (fifoCount)
    );

    assign ent_valid_o = (fifoCount != 2'd0);
    assign ent_index_o = fifoHead[DATA_W +: ADDR_W];
    assign ent_data_o  = fifoHead[DATA_W-1:0];
    assign rd_en_o     = issue;
    assign rd_addr_o   = addr_q;
    assign busy_o      = (state_q != RD_IDLE);
    assign aborted_o   = aborted_q;
    assign skipped_o   = vsEdge & ((state_q != RD_IDLE) | write_begin_i);

endmodule

// File: tb/tb_level_map_reader.sv
// Bench for level_map_reader: a RAM model plus a transaction-level scoreboard checked every cycle.
// Directed scenarios pin the scoreboard with literal latencies and data; a random phase stresses it.
module tb_level_map_reader;

    localparam int AW    = 6;
    localparam int DW    = 16;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vs = 1'b0;
    logic          wb = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          ent_valid;
    logic          ent_ready = 1'b1;
    logic [DW-1:0] ent_data;
    logic [AW-1:0] ent_index;
    logic          busy, frame_done, aborted, skipped;

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] acceptLog [DEPTH];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int readyMode = 0;

    bit mBusy = 0, abortPend = 0, prevStall = 0;
    bit edgeNow, accept, expDone;
    logic [AW+DW-1:0] prevEnt;
    logic [2:0] vsHist;
    int accCnt = 0, issued = 0, scanStart = 0;
    int firstValidDelta = -1, doneDelta = -1;
    int doneCount = 0, abortCount = 0, skipCount = 0;

    level_map_reader dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .vs_i         (vs),
        .write_begin_i(wb),
        .rd_en_o      (rd_en),
        .rd_addr_o    (rd_addr),
        .rd_data_i    (rd_data),
        .ent_valid_o  (ent_valid),
        .ent_ready_i  (ent_ready),
        .ent_data_o   (ent_data),
        .ent_index_o  (ent_index),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .aborted_o    (aborted),
        .skipped_o    (skipped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    // Raw vs as seen by a two-flop synchroniser followed by an edge detector.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) vsHist <= 3'b000;
        else        vsHist <= {vsHist[1:0], vs};
    end

    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       ent_ready = 1'b1;
            1:       ent_ready = ~ent_ready;
            default: ent_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: a scan is a stream of indices 0..63 carrying ram[index]; issues are in order
    // and never leave more than two entries outstanding.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("reset_outputs", {26'd0, busy, frame_done, aborted, skipped, rd_en, ent_valid}, 32'd0);
            mBusy = 0; abortPend = 0; prevStall = 0;
        end else begin
            edgeNow = vsHist[1] && !vsHist[2];
            accept  = ent_valid && ent_ready;
            expDone = mBusy && !wb && accept && (accCnt == DEPTH - 1);
            checkOutput("busy", busy, mBusy);
            checkOutput("skipped", skipped, edgeNow && (mBusy || wb));
            checkOutput("aborted", aborted, abortPend);
            checkOutput("frame_done", frame_done, expDone);
            checkOutput("valid_while_idle", ent_valid && !mBusy, 0);
            if (prevStall) begin
                checkOutput("stall_valid", ent_valid, 1);
                checkOutput("stall_entry", {ent_index, ent_data}, prevEnt);
            end
            if (accept && mBusy) begin
                checkOutput("ent_index", ent_index, accCnt);
                checkOutput("ent_data", ent_data, ram[accCnt % DEPTH]);
                if (accCnt < DEPTH) acceptLog[accCnt] = ent_data;
            end
            if (ent_valid && mBusy && firstValidDelta < 0) firstValidDelta = cyc - scanStart;
            if (rd_en) begin
                checkOutput("rd_en_legal", mBusy && !wb && issued < DEPTH, 1);
                checkOutput("rd_addr", rd_addr, issued);
                checkOutput("outstanding_le2", (issued + 1 - accCnt - int'(accept)) <= 2, 1);
            end
            if (skipped) skipCount++;
            if (aborted) abortCount++;
            if (frame_done) begin
                doneCount++;
                doneDelta = cyc - scanStart;
            end
            prevStall = ent_valid && !ent_ready && mBusy && !wb;
            prevEnt   = {ent_index, ent_data};
            abortPend = mBusy && wb;
            if (rd_en) issued++;
            if (accept && mBusy) accCnt++;
            if (mBusy && (wb || expDone)) begin
                mBusy = 0;
            end else if (!mBusy && edgeNow && !wb) begin
                mBusy = 1; accCnt = 0; issued = 0;
                scanStart = cyc + 1; firstValidDelta = -1;
            end
        end
    end

    task automatic applyStimulus();
        @(posedge clk); #1 vs = 1'b1;
        repeat (4) @(posedge clk);
        #1 vs = 1'b0;
    endtask

    task automatic waitDone(input string name, input int bound);
        int d0;
        int n;
        d0 = doneCount;
        n = 0;
        while (doneCount == d0 && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput(name, doneCount > d0, 1);
    endtask

    initial begin
        int s0, a0, d0, n;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i * 3);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full-throughput scan with linear data
        readyMode = 0;
        applyStimulus();
        waitDone("t1_done", 200);
        checkOutput("t1_first_valid", firstValidDelta, 2);
        checkOutput("t1_done_latency", doneDelta, 65);
        checkOutput("t1_entries", accCnt, 64);
        checkOutput("t1_data_idx10", acceptLog[10], 30);
        checkOutput("t1_data_idx63", acceptLog[63], 189);

        // Consumer stalling every other cycle
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
        readyMode = 1;
        applyStimulus();
        waitDone("t2_done", 400);
        checkOutput("t2_entries", accCnt, 64);

        // vs edge while the writer is busy
        @(posedge clk); #1 wb = 1'b1;
        s0 = skipCount;
        applyStimulus();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t3_skipped", skipCount, s0 + 1);
        checkOutput("t3_busy", busy, 0);
        wb = 1'b0;

        // Abort after 20 accepted entries, then a clean restart
        readyMode = 2;
        a0 = abortCount; d0 = doneCount;
        applyStimulus();
        n = 0;
        while (accCnt < 20 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("t4_reached20", accCnt >= 20, 1);
        @(posedge clk); #1 wb = 1'b1;
        repeat (3) @(posedge clk);
        #1 wb = 1'b0;
        checkOutput("t4_aborted", abortCount, a0 + 1);
        checkOutput("t4_no_done", doneCount, d0);
        checkOutput("t4_partial", accCnt < 64, 1);
        applyStimulus();
        waitDone("t4_restart_done", 600);
        checkOutput("t4_restart_entries", accCnt, 64);

        // Second vs pulse mid-scan is ignored
        readyMode = 0;
        s0 = skipCount;
        applyStimulus();
        repeat (20) @(posedge clk);
        applyStimulus();
        waitDone("t5_done", 300);
        checkOutput("t5_skipped", skipCount, s0 + 1);
        checkOutput("t5_entries", accCnt, 64);

        // Reset in the middle of a scan
        readyMode = 2;
        applyStimulus();
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk); #1;
        checkOutput("t6_busy_in_reset", busy, 0);
        checkOutput("t6_valid_in_reset", ent_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus();
        waitDone("t6_done", 600);
        checkOutput("t6_entries", accCnt, 64);

        // Random vs, writer activity and consumer backpressure
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
        readyMode = 2;
        repeat (1500) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 29) == 0) vs = ~vs;
            if ($urandom_range(0, 99) < 2) wb = 1'b1;
            else if (wb && $urandom_range(0, 2) == 0) wb = 1'b0;
        end
        @(posedge clk); #1 wb = 1'b0; vs = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        checkOutput("t7_idle_at_end", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
